// File: rtl/apple_spawner_if.sv
// Occupancy query port between the apple spawner and the snake-body lookup.
// The spawner drives a cell query; the body lookup answers with ack/hit.
interface apple_spawner_if;
    logic       occ_req;
    logic [6:0] occ_x;
    logic [5:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;

    modport master (output occ_req, occ_x, occ_y, input occ_ack, occ_hit);
    modport slave  (input occ_req, occ_x, occ_y, output occ_ack, occ_hit);
endinterface

// File: rtl/apple_spawner.sv
// Apple relocation controller: draws LFSR cells, checks them against the snake
// body through the occupancy port and commits the first free cell on a frame tick.
module apple_spawner #(
    parameter int          X_MIN     = 2,
    parameter int          X_MAX     = 79,
    parameter int          Y_MIN     = 2,
    parameter int          Y_MAX     = 59,
    parameter int          MAX_TRIES = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic                   got_apple,
    apple_spawner_if.master        occ,
    output logic [9:0]             apple_x,
    output logic [9:0]             apple_y,
    output logic                   apple_valid,
    output logic                   busy,
    output logic                   spawn_done,
    output logic                   spawn_fail
);

    localparam int         TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [6:0] X_LO  = 7'(X_MIN);
    localparam logic [6:0] X_HI  = 7'(X_MAX);
    localparam logic [5:0] Y_LO  = 6'(Y_MIN);
    localparam logic [5:0] Y_HI  = 6'(Y_MAX);

    typedef enum logic [1:0] {IDLE, DRAW, REQ, COMMIT} state_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // cell * 10 as (cell << 3) + (cell << 1); 79 * 10 = 790 fits in 10 bits
    function automatic logic [9:0] cell_to_px(input logic [6:0] c);
        logic [9:0] w;
        w = {3'b000, c};
        return (w << 3) + (w << 1);
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [TRY_W-1:0] try_q, try_d, try_inc;
    logic [6:0]       occ_x_q, occ_x_d, cand_x;
    logic [5:0]       occ_y_q, occ_y_d, cand_y;
    logic [9:0]       apple_x_q, apple_x_d, apple_y_q, apple_y_d;
    logic             apple_valid_q, apple_valid_d;
    logic             spawn_done_q, spawn_done_d, spawn_fail_q, spawn_fail_d;
    logic             arm_q, arm_d;
    logic             in_range, bump;

    assign cand_x   = lfsr_q[6:0];
    assign cand_y   = lfsr_q[13:8];
    assign in_range = (cand_x >= X_LO) && (cand_x <= X_HI) &&
                      (cand_y >= Y_LO) && (cand_y <= Y_HI);
    assign try_inc  = try_q + TRY_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q        <= LFSR_SEED;
            try_q         <= '0;
            occ_x_q       <= '0;
            occ_y_q       <= '0;
            apple_x_q     <= 10'd400;
            apple_y_q     <= 10'd300;
            apple_valid_q <= 1'b1;
            spawn_done_q  <= 1'b0;
            spawn_fail_q  <= 1'b0;
            arm_q         <= 1'b0;
        end else begin
            lfsr_q        <= lfsr_d;
            try_q         <= try_d;
            occ_x_q       <= occ_x_d;
            occ_y_q       <= occ_y_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            apple_valid_q <= apple_valid_d;
            spawn_done_q  <= spawn_done_d;
            spawn_fail_q  <= spawn_fail_d;
            arm_q         <= arm_d;
        end
    end

    // arm_q masks the first edge after reset release so a coincident got_apple is dropped
    always_comb begin
        state_d       = state_q;
        lfsr_d        = lfsr_step(lfsr_q);
        try_d         = try_q;
        occ_x_d       = occ_x_q;
        occ_y_d       = occ_y_q;
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        apple_valid_d = apple_valid_q;
        spawn_done_d  = 1'b0;
        spawn_fail_d  = 1'b0;
        arm_d         = 1'b1;
        bump          = 1'b0;
        case (state_q)
            IDLE: begin
                if (got_apple && arm_q) begin
                    apple_valid_d = 1'b0;
                    try_d         = '0;
                    state_d       = DRAW;
                end
            end
            DRAW: begin
                if (in_range) begin
                    occ_x_d = cand_x;
                    occ_y_d = cand_y;
                    state_d = REQ;
                end else begin
                    bump = 1'b1;
                end
            end
            REQ: begin
                if (occ.occ_ack) begin
                    if (occ.occ_hit) bump = 1'b1;
                    else             state_d = COMMIT;
                end
            end
            COMMIT: begin
                if (frame_tick) begin
                    apple_x_d     = cell_to_px(occ_x_q);
                    apple_y_d     = cell_to_px({1'b0, occ_y_q});
                    apple_valid_d = 1'b1;
                    spawn_done_d  = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Range rejections and body hits share one attempt budget
        if (bump) begin
            try_d = try_inc;
            if (try_inc == TRY_W'(MAX_TRIES)) begin
                spawn_fail_d  = 1'b1;
                apple_valid_d = 1'b1;
                state_d       = IDLE;
            end else begin
                state_d = DRAW;
            end
        end
    end

    always_comb begin
        occ.occ_req = (state_q == REQ);
        busy        = (state_q != IDLE);
    end

    assign occ.occ_x   = occ_x_q;
    assign occ.occ_y   = occ_y_q;
    assign apple_x     = apple_x_q;
    assign apple_y     = apple_y_q;
    assign apple_valid = apple_valid_q;
    assign spawn_done  = spawn_done_q;
    assign spawn_fail  = spawn_fail_q;

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner: directed steps, LFSR reference and a
// queue of predicted occupancy queries.
module tb_apple_spawner;

    typedef struct {
        logic [6:0] x;
        logic [5:0] y;
    } cell_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic frame_tick = 1'b0;
    logic got_apple = 1'b0;
    logic got_apple_b = 1'b0;

    logic [9:0] apple_x, apple_y, apple_x_b, apple_y_b;
    logic apple_valid, busy, spawn_done, spawn_fail;
    logic apple_valid_b, busy_b, spawn_done_b, spawn_fail_b;

    int checks = 0;
    int failures = 0;
    int req_count = 0;
    int cur_x = 400;
    int cur_y = 300;
    logic [15:0] lfsr_m;
    cell_t sb[$];
    cell_t exp_last;

    always #5 clock = ~clock;

    apple_spawner_if ia();
    apple_spawner_if ib();

    apple_spawner dut (
        .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .got_apple(got_apple),
        .occ(ia), .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
        .busy(busy), .spawn_done(spawn_done), .spawn_fail(spawn_fail)
    );

    apple_spawner #(.MAX_TRIES(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .got_apple(got_apple_b),
        .occ(ib), .apple_x(apple_x_b), .apple_y(apple_y_b), .apple_valid(apple_valid_b),
        .busy(busy_b), .spawn_done(spawn_done_b), .spawn_fail(spawn_fail_b)
    );

    // Second instance sees a snake that covers every cell
    assign ib.occ_ack = ib.occ_req;
    assign ib.occ_hit = 1'b1;

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) lfsr_m <= 16'hACE1;
        else          lfsr_m <= nxt(lfsr_m);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // First in-range cell drawn after the cycle whose LFSR value is l0
    task automatic predict_push(input logic [15:0] l0);
        logic [15:0] l;
        cell_t c;
        l = l0;
        for (int k = 0; k < 64; k++) begin
            l = nxt(l);
            if (int'(l[6:0]) >= 2 && int'(l[6:0]) <= 79 &&
                int'(l[13:8]) >= 2 && int'(l[13:8]) <= 59) break;
        end
        c.x = l[6:0];
        c.y = l[13:8];
        sb.push_back(c);
    endtask

    task automatic spawn_start();
        got_apple = 1'b1;
        predict_push(lfsr_m);
        @(negedge clock);
        got_apple = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        cell_t e;
        n = 0;
        while (ia.occ_req !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_req_seen"}, int'(ia.occ_req), 1);
        if (ia.occ_req === 1'b1) begin
            req_count++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                exp_last = e;
                chk({tag, "_occ_x"}, int'(ia.occ_x), int'(e.x));
                chk({tag, "_occ_y"}, int'(ia.occ_y), int'(e.y));
            end else begin
                chk({tag, "_sb_underflow"}, sb.size(), 1);
            end
        end
    endtask

    task automatic ack(input logic hit);
        ia.occ_ack = 1'b1;
        ia.occ_hit = hit;
        if (hit) predict_push(lfsr_m);
        @(negedge clock);
        ia.occ_ack = 1'b0;
        ia.occ_hit = 1'b0;
    endtask

    task automatic commit_check(input string tag);
        int ex, ey;
        ex = int'(exp_last.x) * 10;
        ey = int'(exp_last.y) * 10;
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        chk({tag, "_apple_x"}, int'(apple_x), ex);
        chk({tag, "_apple_y"}, int'(apple_y), ey);
        chk({tag, "_x_range"}, int'(apple_x >= 10'd20 && apple_x <= 10'd790), 1);
        chk({tag, "_y_range"}, int'(apple_y >= 10'd20 && apple_y <= 10'd590), 1);
        chk({tag, "_valid"}, int'(apple_valid), 1);
        chk({tag, "_done"}, int'(spawn_done), 1);
        chk({tag, "_idle"}, int'(busy), 0);
        @(negedge clock);
        chk({tag, "_done_1cyc"}, int'(spawn_done), 0);
        cur_x = ex;
        cur_y = ey;
    endtask

    initial begin
        int bad;
        int fails, dones, seen_busy;
        ia.occ_ack = 1'b0;
        ia.occ_hit = 1'b0;

        // Reset values
        repeat (3) @(negedge clock);
        chk("rst_apple_x", int'(apple_x), 400);
        chk("rst_apple_y", int'(apple_y), 300);
        chk("rst_valid", int'(apple_valid), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_occ_req", int'(ia.occ_req), 0);
        chk("rst_occ_xy", int'({ia.occ_x, ia.occ_y}), 0);
        chk("rst_pulses", int'({spawn_done, spawn_fail}), 0);
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (apple_x !== 10'd400 || apple_y !== 10'd300 || apple_valid !== 1'b1 ||
                busy !== 1'b0 || ia.occ_req !== 1'b0 || spawn_done !== 1'b0) bad++;
        end
        chk("idle_stable", bad, 0);

        // Normal spawn, free on first query, tick five cycles later
        spawn_start();
        chk("norm_valid_low", int'(apple_valid), 0);
        chk("norm_busy", int'(busy), 1);
        wait_req("norm");
        chk("norm_valid_low_req", int'(apple_valid), 0);
        ack(1'b0);
        chk("norm_req_drop", int'(ia.occ_req), 0);
        bad = 0;
        repeat (4) begin
            @(negedge clock);
            if (apple_x !== 10'd400 || apple_valid !== 1'b0 || spawn_done !== 1'b0) bad++;
        end
        chk("norm_hold", bad, 0);
        commit_check("norm");

        // Two body hits then a free cell, each ack delayed three cycles
        req_count = 0;
        spawn_start();
        for (int t = 0; t < 3; t++) begin
            wait_req("coll");
            bad = 0;
            repeat (3) begin
                @(negedge clock);
                if (ia.occ_req !== 1'b1 || ia.occ_x !== exp_last.x || ia.occ_y !== exp_last.y) bad++;
            end
            chk("coll_stable", bad, 0);
            ack(t < 2);
        end
        commit_check("coll");
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (ia.occ_req !== 1'b0) bad++;
        end
        chk("coll_req_count", req_count, 3);
        chk("coll_no_extra", bad, 0);
        chk("coll_sb_empty", sb.size(), 0);

        // frame_tick while idle, then duplicate got_apple and a long frame wait
        frame_tick = 1'b1;
        @(negedge clock);
        frame_tick = 1'b0;
        chk("tick_idle_x", int'(apple_x), cur_x);
        chk("tick_idle_done", int'(spawn_done), 0);
        spawn_start();
        wait_req("gate");
        got_apple = 1'b1;
        @(negedge clock);
        got_apple = 1'b0;
        ack(1'b0);
        bad = 0;
        repeat (1000) begin
            @(negedge clock);
            if (int'(apple_x) != cur_x || int'(apple_y) != cur_y || apple_valid !== 1'b0 ||
                busy !== 1'b1) bad++;
        end
        chk("gate_hold", bad, 0);
        commit_check("gate");
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (busy !== 1'b0 || ia.occ_req !== 1'b0) bad++;
        end
        chk("gate_single_spawn", bad, 0);

        // Asynchronous reset while a query is outstanding
        spawn_start();
        wait_req("mid");
        reset_n = 1'b0;
        #1;
        chk("mid_req_drop", int'(ia.occ_req), 0);
        chk("mid_busy", int'(busy), 0);
        chk("mid_apple_x", int'(apple_x), 400);
        chk("mid_apple_y", int'(apple_y), 300);
        chk("mid_valid", int'(apple_valid), 1);
        chk("mid_occ_xy", int'({ia.occ_x, ia.occ_y}), 0);
        @(negedge clock);
        reset_n = 1'b1;
        sb.delete();
        cur_x = 400;
        cur_y = 300;
        @(negedge clock);
        got_apple = 1'b1;
        predict_push(nxt(16'hACE1));
        @(negedge clock);
        got_apple = 1'b0;
        wait_req("fresh");
        ack(1'b0);
        commit_check("fresh");

        // Exhaustion on the MAX_TRIES=4 instance
        got_apple_b = 1'b1;
        @(negedge clock);
        got_apple_b = 1'b0;
        fails = 0;
        dones = 0;
        seen_busy = 0;
        repeat (60) begin
            if (spawn_fail_b === 1'b1) fails++;
            if (spawn_done_b === 1'b1) dones++;
            if (busy_b === 1'b1) seen_busy++;
            @(negedge clock);
        end
        chk("exh_busy_seen", int'(seen_busy > 0), 1);
        chk("exh_fail_pulses", fails, 1);
        chk("exh_done_pulses", dones, 0);
        chk("exh_busy", int'(busy_b), 0);
        chk("exh_valid", int'(apple_valid_b), 1);
        chk("exh_apple_x", int'(apple_x_b), 400);
        chk("exh_apple_y", int'(apple_y_b), 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apple_spawner.md
# apple_spawner

Controller that sequences relocation of the snake-game apple. On an eaten-apple event it draws pseudo-random grid cells from a free-running LFSR, checks each candidate against the snake body through a request/acknowledge occupancy port, and commits the first free cell to the apple position registers on a frame boundary. It sits between the game logic (`got_apple`, vertical-sync tick) and the apple renderer, which consumes `apple_x`, `apple_y` and `apple_valid`.

## Interface
Parameters:
- `X_MIN`, 2, lowest legal column cell (cell = 10 px)
- `X_MAX`, 79, highest legal column cell
- `Y_MIN`, 2, lowest legal row cell
- `Y_MAX`, 59, highest legal row cell
- `MAX_TRIES`, 16, draw attempts (range rejections plus occupancy hits) before giving up
- `LFSR_SEED`, 16'hACE1, LFSR reset value (must be nonzero)

Ports:
- `clock`  in  1  system clock; all state on rising edge
- `reset_n`  in  1  asynchronous active-low reset
- `frame_tick`  in  1  one-cycle pulse at start of vertical sync
- `got_apple`  in  1  one-cycle pulse: snake head reached apple
- `occ_req`  out  1  occupancy query valid
- `occ_x`  out  7  queried column cell
- `occ_y`  out  6  queried row cell
- `occ_ack`  in  1  occupancy answer valid
- `occ_hit`  in  1  queried cell is snake body; sampled only when `occ_ack`=1
- `apple_x`  out  10  apple column in pixels (cell*10)
- `apple_y`  out  10  apple row in pixels (cell*10)
- `apple_valid`  out  1  apple should be drawn
- `busy`  out  1  spawn sequence in progress (state ≠ IDLE)
- `spawn_done`  out  1  one-cycle pulse: new position committed
- `spawn_fail`  out  1  one-cycle pulse: MAX_TRIES exhausted

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every clock regardless of state; reset to `LFSR_SEED`.
- States: IDLE, DRAW, REQ, COMMIT.
- IDLE: `got_apple`=1 → `apple_valid`<=0, try counter<=0, → DRAW. `got_apple` in any other state is ignored.
- DRAW: candidate cx=lfsr[6:0], cy=lfsr[13:8]. If cx in [X_MIN,X_MAX] and cy in [Y_MIN,Y_MAX]: latch into `occ_x`/`occ_y`, → REQ. Else increment try counter, stay in DRAW (new LFSR value next cycle).
- REQ: `occ_req`=1, `occ_x`/`occ_y` stable. On `occ_ack`: hit=0 → COMMIT; hit=1 → increment try counter, → DRAW. `occ_req` deasserts the cycle after ack.
- Try counter reaching MAX_TRIES (checked on each increment) → `spawn_fail` pulse, `apple_valid`<=1 with unchanged coordinates, → IDLE.
- COMMIT: wait for `frame_tick`; on it, `apple_x`<=cx*10, `apple_y`<=cy*10 (shift-add, 10-bit, max 790/590), `apple_valid`<=1, `spawn_done` pulse next cycle, → IDLE.
- Reset (asynchronous, any state): state IDLE, `apple_x`=400, `apple_y`=300, `apple_valid`=1, `occ_req`=0, `occ_x`=0, `occ_y`=0, `busy`=0, `spawn_done`=0, `spawn_fail`=0, LFSR=seed, try counter=0.

## Timing
- DRAW: 1 cycle per attempt.
- REQ: ≥1 cycle; `occ_ack` may be high in the first `occ_req` cycle. No timeout; the occupancy port must eventually ack.
- Best-case `got_apple` (cycle 0) → DRAW (1) → REQ with ack (2) → COMMIT with `frame_tick` (3) → new coordinates and `spawn_done` visible cycle 4.
- `apple_x`/`apple_y` change only in the cycle after `frame_tick` in COMMIT, or on reset.
- `apple_valid` low from cycle after accepted `got_apple` until commit/fail.
- `frame_tick` outside COMMIT has no effect.
- `got_apple` coincident with reset release ignored.

## Test plan
- Reset: hold `reset_n`=0 → `apple_x`=400, `apple_y`=300, `apple_valid`=1, `busy`=0, `occ_req`=0; release, run 100 cycles with no inputs → outputs unchanged.
- Normal spawn: `got_apple` pulse, ack with hit=0 on first request, `frame_tick` 5 cycles later → coordinates equal LFSR-model cell*10, within 20..790/20..590, `spawn_done` exactly one cycle, `apple_valid` low until commit.
- Collisions: hit=1 on first two acks, 0 on third → exactly three `occ_req` transactions, committed cell matches third query, `occ_x`/`occ_y` stable while `occ_req` high with ack delayed 3 cycles.
- Exhaustion: MAX_TRIES=4, always hit=1 → `spawn_fail` one pulse, `apple_valid`=1 at previous coordinates, `spawn_done` never asserted, `busy`=0.
- Frame gating/ignore: second `got_apple` during REQ ignored (one spawn only); in COMMIT withhold `frame_tick` 1000 cycles → coordinates unchanged until cycle after tick.
- Reset mid-operation: assert `reset_n`=0 while in REQ → `occ_req` drops without clock edge, outputs return to reset values, next `got_apple` starts a fresh sequence from seed.
